mask_tx: RTL and testbench
==========================

# mask_tx

Parametrised M-ary amplitude-shift-keying transmitter: the next generation of the 2ASK transmit path. It accepts parallel data words over a valid/ready handshake and serialises them MSB-first into BPS-bit symbols, each held for SPS samples. Each sample is a continuous-phase DDS sine carrier scaled by the symbol amplitude. The block sits between the framing/data source and the DAC sample interface, and replaces the fixed 2-level modulator plus free-running LUT pair.

## Interface
Parameters:
- DATA_W, 16: input word width; must be an integer multiple of BPS.
- BPS, 2: bits per symbol, 1..4; the block has 2^BPS amplitude levels.
- SPS, 64: samples per symbol, ≥ 2.
- OUT_W, 16: signed output sample width.
- PHASE_W, 32: phase accumulator width.
- LUT_AW, 8: sine ROM address width (2^LUT_AW entries).

Ports:
- sys_clk, in, 1: the only clock.
- sys_rst_n, in, 1: reset, asynchronous and active-low.
- data_in, in, DATA_W: word to transmit.
- data_valid, in, 1: data_in is valid.
- data_ready, out, 1: the block accepts a word on this cycle.
- fcw, in, PHASE_W: carrier frequency control word; sampled every cycle.
- mod_out, out, OUT_W: signed modulated sample.
- mod_valid, out, 1: mod_out carries a live sample.
- sym_strobe, out, 1: one-cycle pulse on the first sample of each symbol.
- busy, out, 1: a word is in flight or the output pipeline is not empty.

## Operation
- **Sine ROM.** ROM[k] = round((2^(OUT_W-1)-1)·sin(2πk/2^LUT_AW)), signed OUT_W, full wave.
- **Phase accumulator.**
  - Free-running on every clock, independent of state: phase <= phase + fcw, wrapping modulo 2^PHASE_W.
  - ROM address = phase[PHASE_W-1 -: LUT_AW].
  - Phase is never reset at word or symbol boundaries, so the carrier is continuous-phase.
- **Symbol mapping.**
  - Symbol s is an unsigned BPS-bit value taken MSB-first from the loaded word.
  - Sample = (ROM[addr] · s) >>> BPS, computed as a signed (OUT_W+BPS+1)-bit product, shifted arithmetically (floor), then truncated to OUT_W. This never overflows.
  - s = 0 outputs 0.
- **FSM states: IDLE and RUN.**
  - IDLE: data_ready = 1. On data_valid & data_ready, load the shift register, set sym_cnt = 0 and samp_cnt = 0, and go to RUN.
  - RUN: samp_cnt counts 0..SPS-1. When it wraps, the shift register advances BPS bits and sym_cnt increments. sym_cnt runs 0..DATA_W/BPS-1.
  - The last sample of the last symbol is the "last cycle". On the last cycle data_ready = 1. If data_valid is also high, the new word loads with zero gap and the FSM stays in RUN; otherwise the FSM goes to IDLE.
  - In RUN, except on the last cycle, data_ready = 0 and data_valid is ignored.
- **busy** = (state == RUN) or any pipeline stage valid.
- **fcw change** takes effect on the next accumulator update. It does not disturb the symbol timing.

## Timing
- **Reset values:**
  - phase = 0, state = IDLE, counters = 0.
  - mod_out = 0, mod_valid = 0, sym_strobe = 0, busy = 0.
  - data_ready reads 1 (IDLE). Inputs are ignored while sys_rst_n is low.
- **Pipeline (2 stages):**
  - Stage 1 registers ROM[addr] and the current s.
  - Stage 2 registers the product and drives mod_out, mod_valid and sym_strobe.
- **Latency:** for a handshake at clock edge T0, the first live sample appears after edge T0+2.
- **Throughput:** one sample per cycle. One word produces exactly (DATA_W/BPS)·SPS consecutive mod_valid cycles. Back-to-back words produce no gap.
- **mod_valid = 0 cycles:** mod_out = 0.
- **sym_strobe** is aligned with mod_valid and is high on sample 0 of every symbol.
- **Reset mid-word:**
  - All outputs clear asynchronously and the word is discarded.
  - After release: IDLE, and the next accepted word starts at symbol 0.

## Test plan
All scenarios use the defaults and fcw = 2^24 (ROM address steps by 1 each cycle). A bench model computes the expected samples, using the same free-running phase from reset.

1. **Reset.** Hold sys_rst_n low for 5 cycles, then release -> mod_out = 0, mod_valid = 0, sym_strobe = 0, busy = 0, data_ready = 1. Phase address increments by 1 per cycle after release.
2. **Single word.** Send data_in = 16'h00E4, one handshake -> mod_valid high for 512 cycles, starting 2 cycles after the handshake.
   - Eight sym_strobe pulses, 64 cycles apart.
   - Symbols are 0,0,0,0,3,2,1,0. Symbol slots 0–3 and 7 output 0.
   - Where ROM = 32767 in symbol 4, the sample is 24575; where ROM = −32767, it is −24576.
3. **Back-to-back.** Hold data_valid high with two words -> 1024 contiguous mod_valid cycles. data_ready pulses for exactly 1 cycle, on the 512th sample cycle of word 1. No phase discontinuity.
4. **fcw change mid-word.** Switch fcw from 2^24 to 2^25 at sample 100 -> the address step becomes 2 from the next cycle. Symbol boundaries and sym_strobe spacing are unchanged, and all samples match the model.
5. **Reset mid-word.** Assert sys_rst_n at sample 100 -> all outputs are 0 immediately (before the next edge). After release, a new word 16'hFFFF yields the full symbol-3 amplitude from the first strobe.
6. **BPS = 1 build.** Send data_in = 16'hAAAA -> symbols alternate 1,0 every 64 cycles. Symbol-1 samples = (ROM·1) >>> 1; the peak is 16383.

Source files
------------

// File: rtl/mask_tx.sv
// mask_tx -- M-ary ASK transmitter.
//
// Takes DATA_W-bit words over a valid/ready handshake. Each word is split
// MSB-first into BPS-bit unsigned symbols, and each symbol is held for SPS
// samples. Every sample is a continuous-phase DDS sine carrier scaled by
// s / 2^BPS, where s is the symbol value.
//
// Ports
//   sys_clk     in   1        clock
//   sys_rst_n   in   1        asynchronous active-low reset
//   data_in     in   DATA_W   word to transmit
//   data_valid  in   1        data_in is valid
//   data_ready  out  1        a word is accepted on this cycle when data_valid is high
//   fcw         in   PHASE_W  carrier frequency control word, applied every cycle
//   mod_out     out  OUT_W    signed modulated sample (0 when mod_valid is low)
//   mod_valid   out  1        mod_out carries a live sample
//   sym_strobe  out  1        high on sample 0 of every symbol
//   busy        out  1        word in flight or output pipeline not empty
//   dbg_state   out  1        FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: a word transfers on any rising edge where data_valid and
// data_ready are both high. data_ready is combinational from the FSM only
// (it never depends on data_valid). It is high in IDLE and on the last
// sample cycle of the last symbol, so back-to-back words run with no gap.
// data_valid is ignored whenever data_ready is low.
module mask_tx #(
  parameter int DATA_W  = 16,
  parameter int BPS     = 2,
  parameter int SPS     = 64,
  parameter int OUT_W   = 16,
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 8
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  input  logic [PHASE_W-1:0]      fcw,
  output logic signed [OUT_W-1:0] mod_out,
  output logic                    mod_valid,
  output logic                    sym_strobe,
  output logic                    busy,
  output logic                    dbg_state
);

  localparam int NSYM   = DATA_W / BPS;
  localparam int SAMP_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int SYM_W  = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int PW     = OUT_W + BPS + 1;
  localparam int LUT_N  = 2 ** LUT_AW;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_load;
  logic                      w_last;
  logic                      w_ready;

  logic [PHASE_W-1:0]        r_phase;
  logic [LUT_AW-1:0]         w_rom_addr;
  logic [DATA_W-1:0]         r_shift;
  logic [SAMP_W-1:0]         r_samp_cnt;
  logic [SYM_W-1:0]          r_sym_cnt;

  logic signed [OUT_W-1:0]   w_rom [LUT_N];

  logic signed [OUT_W-1:0]   r_s1_rom;
  logic [BPS-1:0]            r_s1_sym;
  logic                      r_s1_valid;
  logic                      r_s1_strobe;

  logic signed [PW-1:0]      w_rom_ext;
  logic signed [PW-1:0]      w_sym_ext;
  logic signed [PW-1:0]      w_prod;
  logic signed [OUT_W-1:0]   w_sample;
  logic                      w_unused;

  logic signed [OUT_W-1:0]   r_s2_out;
  logic                      r_s2_valid;
  logic                      r_s2_strobe;

  // Full-wave sine table, elaborated from constants: one rounded entry per
  // address (round half away from zero).
  for (genvar g = 0; g < LUT_N; g++) begin : g_rom
    localparam real ANG = 2.0 * 3.14159265358979323846 * real'(g) / real'(LUT_N);
    localparam real AMP = real'(2 ** (OUT_W - 1) - 1) * $sin(ANG);
    localparam int  VAL = (AMP >= 0.0) ? $rtoi(AMP + 0.5) : -$rtoi(0.5 - AMP);
    assign w_rom[g] = VAL[OUT_W-1:0];
  end

  // Phase accumulator: free-running, never realigned to words or symbols,
  // so the carrier stays continuous across every boundary.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + fcw;
    end
  end

  assign w_rom_addr = r_phase[PHASE_W-1 -: LUT_AW];

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and handshake logic.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_load      = 1'b0;
    w_last      = (r_state == S_RUN) &&
                  (r_samp_cnt == SAMP_W'(SPS - 1)) &&
                  (r_sym_cnt == SYM_W'(NSYM - 1));
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (data_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_ready = 1'b1;
          if (data_valid) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign data_ready = w_ready;
  assign dbg_state  = r_state;

  // Word shift register and symbol/sample counters.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_shift    <= '0;
      r_samp_cnt <= '0;
      r_sym_cnt  <= '0;
    end else if (w_load) begin
      r_shift    <= data_in;
      r_samp_cnt <= '0;
      r_sym_cnt  <= '0;
    end else if (r_state == S_RUN) begin
      if (r_samp_cnt == SAMP_W'(SPS - 1)) begin
        r_samp_cnt <= '0;
        r_shift    <= r_shift << BPS;
        // Park the symbol counter at 0 when the word finishes so IDLE
        // always starts from a clean count.
        if (w_last) begin
          r_sym_cnt <= '0;
        end else begin
          r_sym_cnt <= r_sym_cnt + 1'b1;
        end
      end else begin
        r_samp_cnt <= r_samp_cnt + 1'b1;
      end
    end
  end

  // Stage 1: ROM lookup and the symbol that goes with this sample.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1_rom    <= '0;
      r_s1_sym    <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_strobe <= 1'b0;
    end else begin
      r_s1_rom    <= w_rom[w_rom_addr];
      r_s1_valid  <= (r_state == S_RUN);
      r_s1_strobe <= (r_state == S_RUN) && (r_samp_cnt == '0);
      r_s1_sym    <= (r_state == S_RUN) ? r_shift[DATA_W-1 -: BPS] : '0;
    end
  end

  // Signed product with the symbol zero-extended as a positive value. The
  // arithmetic shift right by BPS is a bit-select of the product, which
  // rounds toward minus infinity. |s| < 2^BPS, so the result always fits
  // in OUT_W bits.
  assign w_rom_ext = {{(BPS + 1){r_s1_rom[OUT_W-1]}}, r_s1_rom};
  assign w_sym_ext = {{(OUT_W + 1){1'b0}}, r_s1_sym};
  assign w_prod    = w_rom_ext * w_sym_ext;
  assign w_sample  = w_prod[BPS +: OUT_W];
  assign w_unused  = ^{w_prod[PW-1], w_prod[BPS-1:0]};

  // Stage 2: output register. Dead cycles are forced to 0.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s2_out    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_strobe <= 1'b0;
    end else begin
      r_s2_out    <= r_s1_valid ? w_sample : '0;
      r_s2_valid  <= r_s1_valid;
      r_s2_strobe <= r_s1_strobe;
    end
  end

  assign mod_out    = r_s2_out;
  assign mod_valid  = r_s2_valid;
  assign sym_strobe = r_s2_strobe;
  assign busy       = (r_state == S_RUN) | r_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_mask_tx.sv
module tb_mask_tx;

  // ---------------- clock / reset / signals ----------------
  logic               sys_clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic [15:0]        data_in = '0;
  logic               data_valid = 1'b0;
  logic [31:0]        fcw = 32'h0100_0000;

  logic               data_ready;
  logic signed [15:0] mod_out;
  logic               mod_valid;
  logic               sym_strobe;
  logic               busy;
  logic               dbg_state;

  logic [15:0]        data_in1 = '0;
  logic               data_valid1 = 1'b0;
  logic               data_ready1;
  logic signed [15:0] mod_out1;
  logic               mod_valid1;
  logic               sym_strobe1;
  logic               busy1;
  logic               dbg_state1;

  always #5 sys_clk = ~sys_clk;

  mask_tx dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .fcw        (fcw),
    .mod_out    (mod_out),
    .mod_valid  (mod_valid),
    .sym_strobe (sym_strobe),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  mask_tx #(.BPS(1)) dut1 (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .data_in    (data_in1),
    .data_valid (data_valid1),
    .data_ready (data_ready1),
    .fcw        (fcw),
    .mod_out    (mod_out1),
    .mod_valid  (mod_valid1),
    .sym_strobe (sym_strobe1),
    .busy       (busy1),
    .dbg_state  (dbg_state1)
  );

  // ---------------- reference model ----------------
  // Bench copy of the free-running phase plus a two-stage delay, so m_a2
  // is the ROM address belonging to the sample on mod_out right now.
  logic [31:0] m_phase = '0;
  int          m_a1 = 0;
  int          m_a2 = 0;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_phase <= '0;
      m_a1    <= 0;
      m_a2    <= 0;
    end else begin
      m_a2    <= m_a1;
      m_a1    <= int'(m_phase[31:24]);
      m_phase <= m_phase + fcw;
    end
  end

  function automatic int rom_val(int a);
    real v;
    v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(a) / 256.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else return -$rtoi(0.5 - v);
  endfunction

  function automatic logic signed [15:0] exp_samp(int a, int s, int bps);
    int p;
    p = rom_val(a) * s;
    p = p >>> bps;
    return p[15:0];
  endfunction

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  cur_sym;

  // ---------------- tests ----------------
  task automatic test_reset();
    sys_rst_n  = 1'b0;
    data_valid = 1'b0;
    fcw        = 32'h0100_0000;
    repeat (5) @(negedge sys_clk);
    n_cmp++;
    if (mod_out !== 16'sd0 || mod_valid !== 1'b0 || sym_strobe !== 1'b0 ||
        busy !== 1'b0 || data_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_hold: out=%0d valid=%b strobe=%b busy=%b ready=%b, required 0/0/0/0/1",
               mod_out, mod_valid, sym_strobe, busy, data_ready);
    end
    sys_rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge sys_clk);
      n_cmp++;
      if (dut.r_phase[31:24] !== i[7:0]) begin
        n_err++;
        $display("FAIL reset_phase_addr: got %0d, required %0d", dut.r_phase[31:24], i);
      end
    end
    n_cmp++;
    if (mod_valid !== 1'b0 || busy !== 1'b0 || data_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: valid=%b busy=%b ready=%b, required 0/0/1",
               mod_valid, busy, data_ready);
    end
  endtask

  task automatic test_single_word();
    logic [15:0]        w;
    logic signed [15:0] e;
    int                 guard;
    w = 16'h00E4;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(4'((w >> (14 - 2 * i)) & 16'h3));
    // Align so symbol 4 sweeps ROM addresses 32..95, which includes the peak.
    guard = 0;
    while (m_phase[31:24] != 8'd31 && guard < 300) begin
      @(negedge sys_clk);
      guard++;
    end
    data_in    = w;
    data_valid = 1'b1;
    @(negedge sys_clk);
    data_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || data_ready !== 1'b0) begin
      n_err++;
      $display("FAIL single_accept: busy=%b ready=%b, required 1/0", busy, data_ready);
    end
    @(negedge sys_clk);
    n_cmp++;
    if (mod_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_latency: mod_valid=%b one cycle after handshake, required 0", mod_valid);
    end
    for (int k = 0; k < 512; k++) begin
      @(negedge sys_clk);
      if (k % 64 == 0) cur_sym = exp_q.pop_front();
      e = exp_samp(m_a2, int'(cur_sym), 2);
      n_cmp++;
      if (mod_valid !== 1'b1 || mod_out !== e || sym_strobe !== (k % 64 == 0)) begin
        n_err++;
        $display("FAIL single_sample k=%0d: valid=%b strobe=%b out=%0d, required 1/%b/%0d",
                 k, mod_valid, sym_strobe, mod_out, (k % 64 == 0), e);
      end
      if (k / 64 == 4 && rom_val(m_a2) == 32767) begin
        n_cmp++;
        if (mod_out !== 16'sd24575) begin
          n_err++;
          $display("FAIL single_peak: got %0d, required 24575", mod_out);
        end
      end
    end
    @(negedge sys_clk);
    n_cmp++;
    if (mod_valid !== 1'b0 || mod_out !== 16'sd0 || busy !== 1'b0 || data_ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_end: valid=%b out=%0d busy=%b ready=%b, required 0/0/0/1",
               mod_valid, mod_out, busy, data_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0]        w1;
    logic [15:0]        w2;
    logic signed [15:0] e;
    logic               rdy_e;
    w1 = 16'h1B6C;
    w2 = 16'hC93F;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(4'((w1 >> (14 - 2 * i)) & 16'h3));
    for (int i = 0; i < 8; i++) exp_q.push_back(4'((w2 >> (14 - 2 * i)) & 16'h3));
    data_in    = w1;
    data_valid = 1'b1;
    @(negedge sys_clk);
    data_in = w2;
    n_cmp++;
    if (data_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_ready_run: got %b, required 0", data_ready);
    end
    @(negedge sys_clk);
    for (int k = 0; k < 1024; k++) begin
      @(negedge sys_clk);
      if (k % 64 == 0) cur_sym = exp_q.pop_front();
      e     = exp_samp(m_a2, int'(cur_sym), 2);
      rdy_e = (k == 509) || (k >= 1021);
      n_cmp++;
      if (mod_valid !== 1'b1 || mod_out !== e || sym_strobe !== (k % 64 == 0) ||
          data_ready !== rdy_e) begin
        n_err++;
        $display("FAIL b2b_sample k=%0d: valid=%b strobe=%b ready=%b out=%0d, required 1/%b/%b/%0d",
                 k, mod_valid, sym_strobe, data_ready, mod_out, (k % 64 == 0), rdy_e, e);
      end
      if (k == 520) data_valid = 1'b0;
    end
    @(negedge sys_clk);
    n_cmp++;
    if (mod_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_end: valid=%b busy=%b, required 0/0", mod_valid, busy);
    end
  endtask

  task automatic test_fcw_change();
    logic [15:0]        w;
    logic signed [15:0] e;
    w = 16'h5A3C;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(4'((w >> (14 - 2 * i)) & 16'h3));
    data_in    = w;
    data_valid = 1'b1;
    @(negedge sys_clk);
    data_valid = 1'b0;
    @(negedge sys_clk);
    for (int k = 0; k < 512; k++) begin
      @(negedge sys_clk);
      if (k % 64 == 0) cur_sym = exp_q.pop_front();
      e = exp_samp(m_a2, int'(cur_sym), 2);
      n_cmp++;
      if (mod_valid !== 1'b1 || mod_out !== e || sym_strobe !== (k % 64 == 0)) begin
        n_err++;
        $display("FAIL fcw_sample k=%0d: valid=%b strobe=%b out=%0d, required 1/%b/%0d",
                 k, mod_valid, sym_strobe, mod_out, (k % 64 == 0), e);
      end
      if (k >= 100 && k <= 103) begin
        n_cmp++;
        if (dut.r_phase !== m_phase) begin
          n_err++;
          $display("FAIL fcw_phase k=%0d: got %h, required %h", k, dut.r_phase, m_phase);
        end
      end
      if (k == 100) fcw = 32'h0200_0000;
    end
    fcw = 32'h0100_0000;
    @(negedge sys_clk);
    n_cmp++;
    if (mod_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL fcw_end: valid=%b busy=%b, required 0/0", mod_valid, busy);
    end
  endtask

  task automatic test_reset_mid_word();
    logic signed [15:0] e;
    data_in    = 16'h3C5A;
    data_valid = 1'b1;
    @(negedge sys_clk);
    data_valid = 1'b0;
    @(negedge sys_clk);
    repeat (101) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mod_out !== 16'sd0 || mod_valid !== 1'b0 || sym_strobe !== 1'b0 ||
        busy !== 1'b0 || data_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_async: out=%0d valid=%b strobe=%b busy=%b ready=%b, required 0/0/0/0/1",
               mod_out, mod_valid, sym_strobe, busy, data_ready);
    end
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    data_in    = 16'hFFFF;
    data_valid = 1'b1;
    @(negedge sys_clk);
    data_valid = 1'b0;
    @(negedge sys_clk);
    for (int k = 0; k < 512; k++) begin
      @(negedge sys_clk);
      e = exp_samp(m_a2, 3, 2);
      n_cmp++;
      if (mod_valid !== 1'b1 || mod_out !== e || sym_strobe !== (k % 64 == 0)) begin
        n_err++;
        $display("FAIL midrst_sample k=%0d: valid=%b strobe=%b out=%0d, required 1/%b/%0d",
                 k, mod_valid, sym_strobe, mod_out, (k % 64 == 0), e);
      end
      if (rom_val(m_a2) == 32767) begin
        n_cmp++;
        if (mod_out !== 16'sd24575) begin
          n_err++;
          $display("FAIL midrst_pos_peak: got %0d, required 24575", mod_out);
        end
      end
      if (rom_val(m_a2) == -32767) begin
        n_cmp++;
        if (mod_out !== -16'sd24576) begin
          n_err++;
          $display("FAIL midrst_neg_peak: got %0d, required -24576", mod_out);
        end
      end
    end
    @(negedge sys_clk);
    n_cmp++;
    if (mod_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_end: valid=%b busy=%b, required 0/0", mod_valid, busy);
    end
  endtask

  task automatic test_bps1();
    logic [15:0]        w;
    logic signed [15:0] e;
    int                 guard;
    w = 16'hAAAA;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(4'((w >> (15 - i)) & 16'h1));
    guard = 0;
    while (m_phase[31:24] != 8'd31 && guard < 300) begin
      @(negedge sys_clk);
      guard++;
    end
    data_in1    = w;
    data_valid1 = 1'b1;
    @(negedge sys_clk);
    data_valid1 = 1'b0;
    @(negedge sys_clk);
    for (int k = 0; k < 1024; k++) begin
      @(negedge sys_clk);
      if (k % 64 == 0) cur_sym = exp_q.pop_front();
      e = exp_samp(m_a2, int'(cur_sym), 1);
      n_cmp++;
      if (mod_valid1 !== 1'b1 || mod_out1 !== e || sym_strobe1 !== (k % 64 == 0)) begin
        n_err++;
        $display("FAIL bps1_sample k=%0d: valid=%b strobe=%b out=%0d, required 1/%b/%0d",
                 k, mod_valid1, sym_strobe1, mod_out1, (k % 64 == 0), e);
      end
      if (cur_sym == 4'd1 && rom_val(m_a2) == 32767) begin
        n_cmp++;
        if (mod_out1 !== 16'sd16383) begin
          n_err++;
          $display("FAIL bps1_peak: got %0d, required 16383", mod_out1);
        end
      end
    end
    @(negedge sys_clk);
    n_cmp++;
    if (mod_valid1 !== 1'b0 || busy1 !== 1'b0 || mod_out1 !== 16'sd0) begin
      n_err++;
      $display("FAIL bps1_end: valid=%b busy=%b out=%0d, required 0/0/0",
               mod_valid1, busy1, mod_out1);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_fcw_change();
    test_reset_mid_word();
    test_bps1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
